decode_stage: RTL and testbench

Registered, parametrised RV32I instruction decoder sitting between instruction fetch and the ALU/register-file stage. It maps each 32-bit instruction to a 6-bit op code. It extracts rd/rs1/rs2 and a sign-extended immediate, and flags unsupported encodings as illegal. Fetch and execute connect through a valid/ready handshake with a 2-entry skid buffer, so throughput is one instruction per cycle under backpressure.

---
 rtl/decode_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction decoder between fetch and execute.
//
// Maps each 32-bit instruction to an op code. Extracts rd/rs1/rs2 and a
// sign-extended immediate, and flags unsupported encodings as illegal.
// Decoded bundles pass through an output register plus one skid register,
// giving one instruction per cycle under backpressure.
//
// Optional feature macro: DECODE_RV32M_EN (decode the RV32M MUL/DIV group).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous drop of all buffered instructions
//   in_valid/in_ready   fetch handshake, instr = raw instruction
//   out_valid/out_ready execute handshake
//   op, rd, rs1, rs2    decoded op code and register fields
//   imm, illegal        sign-extended immediate, unsupported-encoding flag
//   cnt_clr             synchronous clear of illegal_cnt
//   illegal_cnt         saturating count of accepted illegal instructions
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int OPWIDTH   = 6,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPWIDTH-1:0]   op,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [XLEN-1:0]      imm,
  output logic                 illegal,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] illegal_cnt
);

  localparam int BW = OPWIDTH + 15 + XLEN + 1;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] sel_imm;
  logic [31:0] dec_imm;
  logic [5:0]  dec_op;
  logic        dec_ill;
  logic [BW-1:0] dec_bundle;
  logic        accept;

  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [BW-1:0] out_bundle_q, out_bundle_d;
  logic [BW-1:0] skid_bundle_q, skid_bundle_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Instruction decode: op code 0 doubles as the illegal marker.
  always_comb begin
    dec_op  = 6'd0;
    sel_imm = 32'd0;
    // The full 7-bit opcode match also rejects instr[1:0] != 2'b11.
    case (instr[6:0])
      7'b0010011: begin // OP-IMM
        sel_imm = imm_i;
        case (f3)
          3'b000: dec_op = 6'd4;
          3'b010: dec_op = 6'd5;
          3'b011: dec_op = 6'd6;
          3'b100: dec_op = 6'd7;
          3'b110: dec_op = 6'd8;
          3'b111: dec_op = 6'd9;
          3'b001: if (f7 == 7'b0000000) dec_op = 6'd10; else dec_op = 6'd0;
          3'b101: begin
            if (f7 == 7'b0000000)      dec_op = 6'd11;
            else if (f7 == 7'b0100000) dec_op = 6'd12;
            else                       dec_op = 6'd0;
          end
          default: dec_op = 6'd0;
        endcase
      end
      7'b0110011: begin // OP (R-type, no immediate)
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op = 6'd13;
            3'b001:  dec_op = 6'd15;
            3'b010:  dec_op = 6'd16;
            3'b011:  dec_op = 6'd17;
            3'b100:  dec_op = 6'd18;
            3'b101:  dec_op = 6'd19;
            3'b110:  dec_op = 6'd21;
            3'b111:  dec_op = 6'd22;
            default: dec_op = 6'd0;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec_op = 6'd14;
            3'b101:  dec_op = 6'd20;
            default: dec_op = 6'd0;
          endcase
`ifdef DECODE_RV32M_EN
        end else if (f7 == 7'b0000001) begin
          // MUL..REMU are numbered consecutively in funct3 order.
          dec_op = 6'd41 + {3'b000, f3};
`endif
        end else begin
          dec_op = 6'd0;
        end
      end
      7'b0110111: begin dec_op = 6'd23; sel_imm = imm_u; end // LUI
      7'b0010111: begin dec_op = 6'd24; sel_imm = imm_u; end // AUIPC
      7'b1101111: begin dec_op = 6'd25; sel_imm = imm_j; end // JAL
      7'b1100111: begin // JALR
        sel_imm = imm_i;
        if (f3 == 3'b000) dec_op = 6'd26; else dec_op = 6'd0;
      end
      7'b1100011: begin // branches
        sel_imm = imm_b;
        case (f3)
          3'b000:  dec_op = 6'd27;
          3'b001:  dec_op = 6'd28;
          3'b100:  dec_op = 6'd29;
          3'b101:  dec_op = 6'd30;
          3'b110:  dec_op = 6'd31;
          3'b111:  dec_op = 6'd32;
          default: dec_op = 6'd0;
        endcase
      end
      7'b0000011: begin // loads
        sel_imm = imm_i;
        case (f3)
          3'b000:  dec_op = 6'd33;
          3'b001:  dec_op = 6'd34;
          3'b010:  dec_op = 6'd35;
          3'b100:  dec_op = 6'd36;
          3'b101:  dec_op = 6'd37;
          default: dec_op = 6'd0;
        endcase
      end
      7'b0100011: begin // stores
        sel_imm = imm_s;
        case (f3)
          3'b000:  dec_op = 6'd38;
          3'b001:  dec_op = 6'd39;
          3'b010:  dec_op = 6'd40;
          default: dec_op = 6'd0;
        endcase
      end
      default: begin
        dec_op  = 6'd0;
        sel_imm = 32'd0;
      end
    endcase
    // Illegal encodings carry a zero immediate.
    if (dec_op == 6'd0) begin
      dec_ill = 1'b1;
      dec_imm = 32'd0;
    end else begin
      dec_ill = 1'b0;
      dec_imm = sel_imm;
    end
  end

  assign dec_bundle = {OPWIDTH'(dec_op), instr[11:7], instr[19:15], instr[24:20],
                       XLEN'($signed(dec_imm)), dec_ill};

  // in_ready_q tracks "skid empty"; flush masks it in the same cycle.
  assign in_ready = in_ready_q & ~flush;
  assign accept   = in_valid & in_ready;

  // Output/skid buffer next state and illegal counter next state.
  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    out_bundle_d  = out_bundle_q;
    skid_bundle_d = skid_bundle_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output register is free this cycle; the skid entry is older, so it
      // goes first. accept and skid_valid_q never coincide (in_ready_q).
      if (skid_valid_q) begin
        out_bundle_d = skid_bundle_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_bundle_d = dec_bundle;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        skid_bundle_d = dec_bundle;
        skid_valid_d  = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = ~skid_valid_d;

    // accept is already blocked during flush, so no extra flush term here.
    if (cnt_clr) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (accept && dec_ill && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      out_bundle_q  <= {BW{1'b0}};
      skid_bundle_q <= {BW{1'b0}};
      cnt_q         <= {CNT_WIDTH{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      out_bundle_q  <= out_bundle_d;
      skid_bundle_q <= skid_bundle_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign {op, rd, rs1, rs2, imm, illegal} = out_bundle_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboard of expected bundles pushed on the
// input handshake and compared on the output handshake. Uses CNT_WIDTH=2 so
// counter saturation is reachable.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        illegal;
  logic        cnt_clr = 1'b0;
  logic [1:0]  illegal_cnt;

  decode_stage #(.XLEN(32), .OPWIDTH(6), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .illegal(illegal),
    .cnt_clr(cnt_clr), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [5:0]  op;
    logic [31:0] imm;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [1:0] model_cnt = 2'd0;
  logic       hold_v = 1'b0;
  logic [53:0] hold_b;

`ifdef DECODE_RV32M_EN
  localparam logic [5:0] MUL_OP = 6'd41;
`else
  localparam logic [5:0] MUL_OP = 6'd0;
`endif

  vec_t vecs[16] = '{
    '{32'hFFF10093, 6'd4,  32'hFFFFFFFF}, // ADDI x1,x2,-1
    '{32'h402081B3, 6'd14, 32'h00000000}, // SUB x3,x1,x2
    '{32'hFE208EE3, 6'd27, 32'hFFFFFFFC}, // BEQ x1,x2,-4
    '{32'h023100B3, MUL_OP, 32'h00000000}, // MUL x1,x2,x3
    '{32'h7FF36293, 6'd8,  32'h000007FF}, // ORI x5,x6,2047
    '{32'h80047393, 6'd9,  32'hFFFFF800}, // ANDI x7,x8,-2048
    '{32'h123450B7, 6'd23, 32'h12345000}, // LUI
    '{32'h001000EF, 6'd25, 32'h00000800}, // JAL x1,+2048
    '{32'hFE21AC23, 6'd40, 32'hFFFFFFF8}, // SW x2,-8(x3)
    '{32'h4030D093, 6'd12, 32'h00000403}, // SRAI x1,x1,3
    '{32'h40009093, 6'd0,  32'h00000000}, // SLLI with bad funct7
    '{32'h00002063, 6'd0,  32'h00000000}, // branch funct3 010
    '{32'h000010E7, 6'd0,  32'h00000000}, // JALR funct3 001
    '{32'h00000001, 6'd0,  32'h00000000}, // instr[1:0] != 11
    '{32'h00432283, 6'd35, 32'h00000004}, // LW x5,4(x6)
    '{32'hFFFFF117, 6'd24, 32'hFFFFF000}  // AUIPC x2,0xFFFFF
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Hold in_valid with one instruction until accepted (bounded).
  task automatic send(input logic [31:0] ins, input logic [5:0] eop, input logic [31:0] eimm);
    logic acc;
    int   n;
    cur = '{op: eop, rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20],
            imm: eimm, ill: (eop == 6'd0)};
    instr    = ins;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      model_cnt = 2'd0;
      hold_v    = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_bundle", 64'({op, rd, rs1, rs2, imm, illegal}), 64'(hold_b));
      end
      hold_v = out_valid && !out_ready && !flush;
      hold_b = {op, rd, rs1, rs2, imm, illegal};
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("op", 64'(op), 64'(e.op));
          check("rd", 64'(rd), 64'(e.rd));
          check("rs1", 64'(rs1), 64'(e.rs1));
          check("rs2", 64'(rs2), 64'(e.rs2));
          check("imm", 64'(imm), 64'(e.imm));
          check("illegal", 64'(illegal), 64'(e.ill));
        end
      end
      check("cnt", 64'(illegal_cnt), 64'(model_cnt));
      if (flush) sb_q.delete();
      if (cnt_clr) model_cnt = 2'd0;
      else if (in_valid && in_ready && cur.ill && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
      if (in_valid && in_ready) sb_q.push_back(cur);
    end
  end

  logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] saved_cnt;
  logic       rnd_done;

  initial begin
    // Reset values.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op", 64'(op), 64'd0);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Streaming with out_ready held high: one per cycle, latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(vecs[i].ins, vecs[i].op, vecs[i].imm);
    drain();

    // Streaming with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++)
          for (int i = 0; i < 16; i++) send(vecs[i].ins, vecs[i].op, vecs[i].imm);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: ADDI, ORI, ANDI with out_ready low.
    out_ready = 1'b0;
    send(32'hFFF10093, 6'd4, 32'hFFFFFFFF);
    @(negedge clk);
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(32'h7FF36293, 6'd8, 32'h000007FF);
    @(negedge clk);
    check("bp_ready_after_2", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      send(32'h80047393, 6'd9, 32'hFFFFF800);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation with CNT_WIDTH=2, then clear beating an increment.
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'h00000000, 6'd0, 32'd0);
      check("cnt_seq", 64'(illegal_cnt), 64'(cnt_exp[i]));
    end
    cnt_clr = 1'b1;
    send(32'h00000000, 6'd0, 32'd0);
    cnt_clr = 1'b0;
    check("cnt_clr_wins", 64'(illegal_cnt), 64'd0);
    drain();

    // Flush with both entries full and input offered.
    out_ready = 1'b0;
    send(32'hFFF10093, 6'd4, 32'hFFFFFFFF);
    send(32'h7FF36293, 6'd8, 32'h000007FF);
    saved_cnt = illegal_cnt;
    cur = '{op: 6'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, ill: 1'b1};
    instr = 32'h00000000; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_out_valid", 64'(out_valid), 64'd0);
    check("flush_full_in_ready_after", 64'(in_ready), 64'd1);
    check("flush_full_cnt", 64'(illegal_cnt), 64'(saved_cnt));

    // Flush while the decoder would otherwise accept an illegal instruction.
    @(posedge clk); #1;
    send(32'hFFF10093, 6'd4, 32'hFFFFFFFF);
    saved_cnt = illegal_cnt;
    instr = 32'h00000000; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_half_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_half_out_valid", 64'(out_valid), 64'd0);
    check("flush_half_cnt", 64'(illegal_cnt), 64'(saved_cnt));
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h402081B3, 6'd14, 32'h00000000);
    drain();

    // Reset mid-stream with both entries full.
    out_ready = 1'b0;
    send(32'h00000000, 6'd0, 32'd0);
    send(32'hFE21AC23, 6'd40, 32'hFFFFFFF8);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_op", 64'(op), 64'd0);
    check("mid_rst_rd", 64'(rd), 64'd0);
    check("mid_rst_imm", 64'(imm), 64'd0);
    check("mid_rst_illegal", 64'(illegal), 64'd0);
    check("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFF10093, 6'd4, 32'hFFFFFFFF);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
